// File: rtl/vad_pkg.sv
// Shared types and helpers for the voice-activity decision path.
package vad_pkg;

  typedef enum logic [1:0] {
    SILENCE  = 2'd0,
    ONSET    = 2'd1,
    SPEECH   = 2'd2,
    HANGOVER = 2'd3
  } vad_state_t;

  localparam logic [7:0]  FLOAT_NAN_EXP     = 8'hFF;
  localparam logic [31:0] DEFAULT_THRESHOLD = 32'h40A00000;

  // Maps a float32 onto an unsigned key whose integer order matches float order.
  function automatic logic [31:0] float_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/vad_decision_float_gt_cmp.sv
// Combinational float32 greater-than; a NaN on input a never compares greater.
module float_gt_cmp
  import vad_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  logic a_nan;

  assign a_nan = (a[30:23] == FLOAT_NAN_EXP) && (a[22:0] != 23'd0);
  assign gt    = !a_nan && (float_key(a) > float_key(b));

endmodule

// File: rtl/vad_decision.sv
// Per-frame speech/silence decision with warm-up, onset and hangover smoothing.
module vad_decision
  import vad_pkg::*;
#(
  parameter int unsigned ONSET_FRAMES  = 3,
  parameter int unsigned HANG_FRAMES   = 8,
  parameter int unsigned WARMUP_FRAMES = 4,
  parameter int unsigned IDX_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tready_log_energy,
  input  logic [31:0]          log_energy,
  input  logic [31:0]          threshold,
  output logic                 tvalid_vad,
  output logic                 vad_flag,
  output logic                 speech_start,
  output logic                 speech_end,
  output logic [IDX_WIDTH-1:0] frame_idx
);

  localparam logic [7:0] ONSET_N = 8'(ONSET_FRAMES);
  localparam logic [7:0] HANG_N  = 8'(HANG_FRAMES);
  localparam logic [7:0] WARM_N  = 8'(WARMUP_FRAMES);

  vad_state_t           state, state_nxt;
  logic [7:0]           run_cnt, run_nxt;
  logic [7:0]           warm_cnt, warm_nxt;
  logic [IDX_WIDTH-1:0] idx_cnt;
  logic                 above;
  logic                 flag_nxt;

  float_gt_cmp u_cmp (
    .a  (log_energy),
    .b  (threshold),
    .gt (above)
  );

  // Next-state view of the current strobe; only committed when a strobe is present.
  always_comb begin
    state_nxt = state;
    run_nxt   = run_cnt;
    warm_nxt  = warm_cnt;
    if (warm_cnt < WARM_N) begin
      warm_nxt  = warm_cnt + 8'd1;
      state_nxt = SILENCE;
      run_nxt   = 8'd0;
    end else begin
      unique case (state)
        SILENCE: begin
          if (above) begin
            if (ONSET_N == 8'd1) begin
              state_nxt = SPEECH;
              run_nxt   = 8'd0;
            end else begin
              state_nxt = ONSET;
              run_nxt   = 8'd1;
            end
          end
        end
        ONSET: begin
          if (above) begin
            if (run_cnt + 8'd1 == ONSET_N) begin
              state_nxt = SPEECH;
              run_nxt   = 8'd0;
            end else begin
              run_nxt = run_cnt + 8'd1;
            end
          end else begin
            state_nxt = SILENCE;
            run_nxt   = 8'd0;
          end
        end
        SPEECH: begin
          if (!above) begin
            if (HANG_N == 8'd0) begin
              state_nxt = SILENCE;
              run_nxt   = 8'd0;
            end else begin
              state_nxt = HANGOVER;
              run_nxt   = 8'd1;
            end
          end
        end
        HANGOVER: begin
          if (above) begin
            state_nxt = SPEECH;
            run_nxt   = 8'd0;
          end else if (run_cnt == HANG_N) begin
            state_nxt = SILENCE;
            run_nxt   = 8'd0;
          end else begin
            run_nxt = run_cnt + 8'd1;
          end
        end
        default: begin
          state_nxt = SILENCE;
          run_nxt   = 8'd0;
        end
      endcase
    end
    flag_nxt = (state_nxt == SPEECH) || (state_nxt == HANGOVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SILENCE;
      run_cnt      <= 8'd0;
      warm_cnt     <= 8'd0;
      idx_cnt      <= '0;
      tvalid_vad   <= 1'b0;
      vad_flag     <= 1'b0;
      speech_start <= 1'b0;
      speech_end   <= 1'b0;
      frame_idx    <= '0;
    end else begin
      tvalid_vad   <= tready_log_energy;
      speech_start <= 1'b0;
      speech_end   <= 1'b0;
      if (tready_log_energy) begin
        state        <= state_nxt;
        run_cnt      <= run_nxt;
        warm_cnt     <= warm_nxt;
        vad_flag     <= flag_nxt;
        speech_start <= flag_nxt & ~vad_flag;
        speech_end   <= ~flag_nxt & vad_flag;
        frame_idx    <= idx_cnt;
        idx_cnt      <= idx_cnt + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: doc/vad_decision.md
# vad_decision

Frame-level voice-activity decision stage directly downstream of the frame log-energy stage. Consumes one IEEE-754 single-precision log-energy strobe per 512-sample frame and compares it against a run-time threshold. Applies warm-up, onset and hangover smoothing, then emits a registered per-frame speech/silence flag with start/end event pulses for the VAD output logic.

## Interface
Parameters:
- ONSET_FRAMES, 3: consecutive above-threshold frames required to enter speech; legal range 1..255.
- HANG_FRAMES, 8: below-threshold frames still flagged speech after the last above-threshold frame; legal range 0..255.
- WARMUP_FRAMES, 4: strobes after reset forced to silence, which absorbs start-up log outputs; legal range 0..255.
- IDX_WIDTH, 16: width of the frame index.

Ports:
- clk  in  1  system clock; the block uses one clock.
- reset  in  1  synchronous, active-high.
- tready_log_energy  in  1  single-cycle strobe; log_energy is valid in this cycle.
- log_energy  in  32  float32 natural log of frame energy.
- threshold  in  32  float32 decision threshold, sampled in the strobe cycle.
- tvalid_vad  out  1  single-cycle pulse, one per accepted strobe.
- vad_flag  out  1  decision for the frame; 1 means speech.
- speech_start  out  1  pulses with tvalid_vad when vad_flag goes 0→1.
- speech_end  out  1  pulses with tvalid_vad when vad_flag goes 1→0.
- frame_idx  out  IDX_WIDTH  index of the frame being reported.

## Operation
- **Compare rule.** "Above" means log_energy > threshold in float ordering.
  - Map key(x) = sign ? ~x : x ^ 32'h80000000, then do an unsigned compare.
  - A NaN log_energy (exponent 8'hFF, mantissa ≠ 0) always counts as below.
  - -0 < +0 is accepted.
- **Warm-up.** warm_cnt counts accepted strobes up to WARMUP_FRAMES. While warm_cnt < WARMUP_FRAMES:
  - the strobe is reported with vad_flag=0;
  - the FSM stays in SILENCE and all FSM counters stay at 0.
- **FSM states:** SILENCE, ONSET, SPEECH, HANGOVER. Transitions occur only on a post-warm-up strobe. run_cnt is an 8-bit counter.
  - SILENCE, above: if ONSET_FRAMES==1 go to SPEECH, else go to ONSET with run_cnt=1. Below: stay.
  - ONSET, above: run_cnt+1; on reaching ONSET_FRAMES go to SPEECH. Below: go to SILENCE, run_cnt=0.
  - SPEECH, above: stay. Below: if HANG_FRAMES==0 go to SILENCE, else go to HANGOVER with run_cnt=1.
  - HANGOVER, above: go to SPEECH, run_cnt=0. Below: if run_cnt==HANG_FRAMES go to SILENCE, else run_cnt+1.
- **Flag.** vad_flag is 1 iff the next state is SPEECH or HANGOVER. ONSET frames report 0 and are not back-filled.
- **Events.** speech_start / speech_end compare the new vad_flag with the previously reported flag. They are never both 1.
- **Frame index.** frame_idx reports the count of strobes accepted since reset (first frame = 0). It increments after each report and wraps modulo 2^IDX_WIDTH with no other effect.

## Timing
- **Latency.** A strobe in cycle n gives tvalid_vad and all decision outputs registered in cycle n+1.
- **Output hold.** vad_flag and frame_idx hold their values until the next report. speech_start and speech_end are high only in the tvalid_vad cycle.
- **Back-to-back.** Strobes on consecutive cycles are each processed with no loss. There is no backpressure; the block always accepts.
- **Reset values.** All outputs are 0, state is SILENCE, and warm_cnt, run_cnt and the index counter are 0.
- **Reset priority.** Reset wins over a simultaneous strobe; that strobe is dropped. Reset during ONSET or HANGOVER discards the partial run with no speech_end pulse, and warm-up restarts.
- **Threshold changes.** A threshold change takes effect on the next strobe. No state is recomputed.

## Structure
- **Shared package vad_pkg:**
  - state encoding constants;
  - FLOAT_NAN_EXP = 8'hFF;
  - the float-key ordering function;
  - a default threshold constant 32'h40A00000 (5.0).
- **Sub-module float_gt_cmp (combinational):** inputs a[31:0], b[31:0]; output gt, with NaN on a giving 0. It is reused by later threshold stages.
- **Top level:** registered FSM, counters and output registers.

## Test plan
- **Warm-up.** After reset, 4 strobes of 8.0 with threshold=5.0 → four tvalid_vad pulses, vad_flag=0, frame_idx 0..3, no speech_start.
- **Onset.** After warm-up: 2 frames of 8.0, 1 frame of 1.0, then 3 frames of 8.0 → flags 0,0,0,0,0,1; speech_start with the 6th frame only.
- **Hangover.** In SPEECH: 8 frames of -2.0 → flag 1; 9th frame → flag 0 with speech_end. Repeat with an above frame at hangover frame 5 → return to SPEECH, no speech_end.
- **Float edge values.** threshold=-1.0, log_energy=-0.5 → above; log_energy=32'h7FC00000 (NaN) → below; log_energy equal to threshold → below.
- **Throughput and wrap.** Strobe every cycle for 70000 frames of alternating runs → one tvalid_vad per strobe at +1 cycle; frame_idx wraps 65535→0.
- **Mid-run reset.** Reset asserted in the same cycle as a strobe while in HANGOVER → no tvalid_vad for that strobe, all outputs 0 next cycle, warm-up restarts at frame_idx 0.
